// File: rtl/dmem_responder.sv
// Data-memory responder: a word-addressed array behind an IDLE/WAIT/DONE FSM
// that stalls the MEM stage for LATENCY cycles and reports illegal accesses.
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        mem_err,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a request (mem_ren|mem_wen) is taken only in IDLE; the requester
  // holds while mem_stall=1 and the access completes on the single mem_ack cycle.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_din;
  logic                    r_wr;
  logic [31:0]             r_dout;
  logic                    r_ack;
  logic                    r_err;
  logic [31:0]             r_mem [0:DEPTH-1];

  logic                    w_req;
  logic                    w_bad;
  logic                    w_stall;
  logic                    w_err_nxt;
  logic                    w_access;
  logic                    w_acc_wr;
  logic [ADDR_WIDTH-1:0]   w_acc_idx;
  logic [31:0]             w_acc_din;

  assign w_req = mem_ren | mem_wen;
  assign w_bad = (mem_ren & mem_wen) | (|mem_addr[1:0]) | (|mem_addr[31:ADDR_WIDTH+2]);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_err_nxt   = 1'b0;
    w_access    = 1'b0;
    w_acc_wr    = r_wr;
    w_acc_idx   = r_idx;
    w_acc_din   = r_din;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_bad) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_stall = 1'b1;
            if (LATENCY == 1) begin
              // Single-cycle latency commits straight from the live inputs.
              w_state_nxt = S_DONE;
              w_access    = 1'b1;
              w_acc_wr    = mem_wen;
              w_acc_idx   = mem_addr[ADDR_WIDTH+1:2];
              w_acc_din   = mem_din;
            end else begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = 4'(CNT_INIT);
            end
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_dout  <= 32'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= (w_state_nxt == S_DONE);
      r_err   <= w_err_nxt;
      if (w_access && !w_acc_wr) r_dout <= r_mem[w_acc_idx];
    end
  end

  // Request latch and array have no reset; array contents survive rst_n.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_req) begin
      r_idx <= mem_addr[ADDR_WIDTH+1:2];
      r_din <= mem_din;
      r_wr  <= mem_wen;
    end
    if (rst_n && w_access && w_acc_wr) r_mem[w_acc_idx] <= w_acc_din;
  end

  assign mem_stall   = rst_n & w_stall;
  assign mem_dout    = r_dout;
  assign mem_ack     = r_ack;
  assign mem_err     = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances (LATENCY 2,1,4,15) driven from one
// sequence, with a reference memory model and an expected-dout queue.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n [4];
  logic        ren   [4];
  logic        wen   [4];
  logic [31:0] addr  [4];
  logic [31:0] din   [4];
  logic [31:0] dout  [4];
  logic        stall [4];
  logic        ack   [4];
  logic        err   [4];
  logic [1:0]  dbg   [4];

  logic [31:0] exp_q[$];
  logic [31:0] mdl      [4][256];
  logic [31:0] mdl_dout [4];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH(8),
      .LATENCY   ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 15)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .mem_ren    (ren[g]),
      .mem_wen    (wen[g]),
      .mem_addr   (addr[g]),
      .mem_din    (din[g]),
      .mem_dout   (dout[g]),
      .mem_stall  (stall[g]),
      .mem_ack    (ack[g]),
      .mem_err    (err[g]),
      .o_dbg_state(dbg[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 4 : 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs(input int k);
    ren[k]  = 1'b0;
    wen[k]  = 1'b0;
    addr[k] = 32'd0;
    din[k]  = 32'd0;
  endtask

  // mode 0: drop request after acceptance; 1: hold through DONE;
  // 2: hold op but change address/data while the access is in flight.
  task automatic do_req(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int mode, input bit sync, input bit tail);
    int   cyc;
    int   nstall;
    int   lat_exp;
    bit   bad;
    logic [31:0] e;
    bad     = (r && w) || (a[1:0] != 2'd0) || (a[31:10] != 22'd0);
    lat_exp = bad ? 1 : lat_of(k);
    if (sync) @(negedge clk);
    ren[k] = r; wen[k] = w; addr[k] = a; din[k] = d;
    #1;
    check($sformatf("u%0d stall_at_accept a=%h", k, a), 32'(stall[k]), 32'(!bad));
    nstall = stall[k] ? 1 : 0;
    if (!bad && r) mdl_dout[k] = mdl[k][a[9:2]];
    if (!bad && w) mdl[k][a[9:2]] = d;
    exp_q.push_back(mdl_dout[k]);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mode == 0 && cyc == 1) idle_inputs(k);
      if (mode == 2 && cyc == 1) begin
        addr[k] = a ^ 32'h0000_000C;
        din[k]  = ~d;
      end
      #1;
      if (ack[k]) break;
      if (stall[k]) nstall++;
    end
    check($sformatf("u%0d ack_seen a=%h", k, a), 32'(ack[k]), 32'd1);
    check($sformatf("u%0d latency a=%h", k, a), 32'(cyc), 32'(lat_exp));
    check($sformatf("u%0d stall_cycles a=%h", k, a), 32'(nstall), bad ? 32'd0 : 32'(lat_of(k)));
    check($sformatf("u%0d stall_in_done a=%h", k, a), 32'(stall[k]), 32'd0);
    check($sformatf("u%0d err a=%h", k, a), 32'(err[k]), 32'(bad));
    e = exp_q.pop_front();
    check($sformatf("u%0d dout a=%h", k, a), dout[k], e);
    if (tail) begin
      @(negedge clk);
      idle_inputs(k);
      #1;
      check($sformatf("u%0d single_ack a=%h", k, a), 32'(ack[k]), 32'd0);
    end
  endtask

  initial begin
    int acks;
    for (int k = 0; k < 4; k++) begin
      rst_n[k] = 1'b0;
      idle_inputs(k);
      ren[k] = 1'b1;
      mdl_dout[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("u%0d rst_stall", k), 32'(stall[k]), 32'd0);
      check($sformatf("u%0d rst_ack", k), 32'(ack[k]), 32'd0);
      check($sformatf("u%0d rst_err", k), 32'(err[k]), 32'd0);
      check($sformatf("u%0d rst_dout", k), dout[k], 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      idle_inputs(k);
      rst_n[k] = 1'b1;
    end
    // First cycle out of reset: request must be taken immediately.
    do_req(0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 0, 1'b0, 1'b1);
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b1, 1'b1);
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 1, 1'b1, 1'b1);
    do_req(0, 1'b0, 1'b1, 32'h48, 32'h0102_0304, 0, 1'b1, 1'b1);
    do_req(0, 1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, 2, 1'b1, 1'b1);
    do_req(0, 1'b1, 1'b0, 32'h44, 32'h0, 0, 1'b1, 1'b1);
    do_req(0, 1'b1, 1'b0, 32'h48, 32'h0, 0, 1'b1, 1'b1);
    do_req(0, 1'b1, 1'b1, 32'h40, 32'h1111_1111, 0, 1'b1, 1'b1);
    do_req(0, 1'b1, 1'b0, 32'h41, 32'h0, 0, 1'b1, 1'b1);
    do_req(0, 1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF, 0, 1'b1, 1'b1);
    do_req(0, 1'b0, 1'b1, 32'h42, 32'h5555_5555, 0, 1'b1, 1'b1);
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b1, 1'b1);
    do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      do_req(0, 1'b0, 1'b1, 32'h80 + 32'(i * 4), $urandom, 0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      int idx;
      idx = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1)
        do_req(0, 1'b0, 1'b1, 32'h80 + 32'(idx * 4), $urandom, 0, 1'b1, 1'b1);
      else
        do_req(0, 1'b1, 1'b0, 32'h80 + 32'(idx * 4), 32'h0, 0, 1'b1, 1'b1);
    end

    do_req(1, 1'b0, 1'b1, 32'h04, 32'h1234_5678, 0, 1'b1, 1'b1);
    do_req(1, 1'b1, 1'b0, 32'h04, 32'h0, 0, 1'b1, 1'b1);
    do_req(1, 1'b1, 1'b0, 32'h04, 32'h0, 1, 1'b1, 1'b1);
    do_req(1, 1'b1, 1'b0, 32'h404, 32'h0, 0, 1'b1, 1'b1);
    do_req(1, 1'b0, 1'b1, 32'h10, 32'h7777_8888, 2, 1'b1, 1'b1);
    do_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b1, 1'b1);

    do_req(2, 1'b0, 1'b1, 32'h08, 32'h1111_2222, 0, 1'b1, 1'b1);
    @(negedge clk);
    wen[2] = 1'b1; addr[2] = 32'h08; din[2] = 32'hAAAA_5555;
    #1;
    check("u2 stall_before_abort", 32'(stall[2]), 32'd1);
    @(negedge clk);
    idle_inputs(2);
    @(negedge clk);
    rst_n[2] = 1'b0;
    wen[2] = 1'b1; addr[2] = 32'h0C;
    #1;
    check("u2 stall_forced_low", 32'(stall[2]), 32'd0);
    @(negedge clk);
    idle_inputs(2);
    rst_n[2] = 1'b1;
    mdl_dout[2] = 32'd0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ack[2]) acks++;
      @(negedge clk);
    end
    check("u2 no_ack_after_abort", 32'(acks), 32'd0);
    check("u2 dout_after_abort", dout[2], 32'd0);
    do_req(2, 1'b1, 1'b0, 32'h08, 32'h0, 0, 1'b1, 1'b1);

    do_req(3, 1'b0, 1'b1, 32'h0C, 32'h0BAD_F00D, 0, 1'b1, 1'b0);
    do_req(3, 1'b1, 1'b0, 32'h0C, 32'h0, 0, 1'b1, 1'b1);
    do_req(3, 1'b1, 1'b0, 32'h0D, 32'h0, 0, 1'b1, 1'b1);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
